tic_tac_toe_game: RTL and testbench

- Two-player tic-tac-toe controller for a 3x3 board of push-buttons (cells a..i, row-major: a b c / d e f / g h i) with one LED per cell.
- Tracks cell ownership and whose turn it is, detects a win on any of the 8 lines, and flags a full grid.
- Sits between debounced board buttons and the front-panel LEDs/status indicators.

---
 rtl/ttt_pkg.sv | 34 +++
 rtl/ttt_line_check.sv | 30 +++
 rtl/tic_tac_toe_game.sv | 96 +++++++++
 tb/tb_tic_tac_toe_game.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared cell/turn types and board geometry for the tic-tac-toe controller.
package ttt_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef enum logic {
        TURN_P1 = 1'b0,
        TURN_P2 = 1'b1
    } turn_t;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    localparam int A = 0;
    localparam int B = 1;
    localparam int C = 2;
    localparam int D = 3;
    localparam int E = 4;
    localparam int F = 5;
    localparam int G = 6;
    localparam int H = 7;
    localparam int I = 8;

    localparam int LINES [NUM_LINES][3] = '{
        '{A, B, C}, '{D, E, F}, '{G, H, I},
        '{A, D, G}, '{B, E, H}, '{C, F, I},
        '{A, E, I}, '{C, E, G}
    };

endpackage

// File: rtl/ttt_line_check.sv
// Combinational win/full evaluator over the registered 9-cell board.
module ttt_line_check
    import ttt_pkg::*;
(
    input  cell_t [NUM_CELLS-1:0] cells,
    output logic                  p1_win,
    output logic                  p2_win,
    output logic                  grid_full
);

    always_comb begin
        p1_win    = 1'b0;
        p2_win    = 1'b0;
        grid_full = 1'b1;
        for (int l = 0; l < NUM_LINES; l++) begin
            if (cells[LINES[l][0]] == P1 &&
                cells[LINES[l][1]] == P1 &&
                cells[LINES[l][2]] == P1)
                p1_win = 1'b1;
            if (cells[LINES[l][0]] == P2 &&
                cells[LINES[l][1]] == P2 &&
                cells[LINES[l][2]] == P2)
                p2_win = 1'b1;
        end
        for (int k = 0; k < NUM_CELLS; k++)
            if (cells[k] == EMPTY)
                grid_full = 1'b0;
    end

endmodule

// File: rtl/tic_tac_toe_game.sv
// Two-player tic-tac-toe controller: button edge capture, move
// arbitration, turn tracking and LED mapping.
module tic_tac_toe_game
    import ttt_pkg::*;
#(
    parameter int BLINK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic a, b, c, d, e, f, g, h, i,
    output logic p1_turn,
    output logic p2_turn,
    output logic p1_win,
    output logic p2_win,
    output logic grid_full,
    output logic a_led, b_led, c_led,
    output logic d_led, e_led, f_led,
    output logic g_led, h_led, i_led
);

    logic [NUM_CELLS-1:0] btn, bsamp, bprev, press, led;
    cell_t [NUM_CELLS-1:0] cells, cells_d;
    turn_t                 turn, turn_d;
    logic [BLINK_DIV-1:0]  div;
    logic [3:0]            pick;
    logic                  pick_ok, move_ok, game_over, blink;
    cell_t                 mover;

    assign btn   = {i, h, g, f, e, d, c, b, a};
    assign press = bsamp & ~bprev;

    ttt_line_check u_line_check (
        .cells     (cells),
        .p1_win    (p1_win),
        .p2_win    (p2_win),
        .grid_full (grid_full)
    );

    assign game_over = p1_win | p2_win | grid_full;
    assign p1_turn   = ~game_over & (turn == TURN_P1);
    assign p2_turn   = ~game_over & (turn == TURN_P2);
    assign mover     = (turn == TURN_P1) ? P1 : P2;

    // Scan from i down to a so the lowest eligible index wins.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        for (int k = NUM_CELLS - 1; k >= 0; k--) begin
            if (press[k] && cells[k] == EMPTY) begin
                pick    = 4'(k);
                pick_ok = 1'b1;
            end
        end
    end

    assign move_ok = pick_ok & ~game_over;

    always_comb begin
        cells_d = cells;
        turn_d  = turn;
        if (move_ok) begin
            cells_d[pick] = mover;
            turn_d = (turn == TURN_P1) ? TURN_P2 : TURN_P1;
        end
    end

    // Live buttons load both history stages so a held key stays silent.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CELLS; k++)
                cells[k] <= EMPTY;
            turn  <= TURN_P1;
            bsamp <= btn;
            bprev <= btn;
            div   <= '0;
        end else begin
            cells <= cells_d;
            turn  <= turn_d;
            bsamp <= btn;
            bprev <= bsamp;
            div   <= div + 1'b1;
        end
    end

    assign blink = div[BLINK_DIV-1];

    always_comb begin
        led = '0;
        for (int k = 0; k < NUM_CELLS; k++)
            led[k] = (cells[k] == P1) | ((cells[k] == P2) & blink);
    end

    assign {i_led, h_led, g_led, f_led, e_led,
            d_led, c_led, b_led, a_led} = led;

endmodule

// File: tb/tb_tic_tac_toe_game.sv
// Self-checking bench: directed game scenarios plus random button traffic
// compared every cycle against a board-level reference model.
module tb_tic_tac_toe_game;

    localparam int BD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [8:0] btn = '0;
    logic p1_turn, p2_turn, p1_win, p2_win, grid_full;
    logic a_led, b_led, c_led, d_led, e_led, f_led, g_led, h_led, i_led;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tic_tac_toe_game #(.BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset),
        .a(btn[0]), .b(btn[1]), .c(btn[2]),
        .d(btn[3]), .e(btn[4]), .f(btn[5]),
        .g(btn[6]), .h(btn[7]), .i(btn[8]),
        .p1_turn(p1_turn), .p2_turn(p2_turn),
        .p1_win(p1_win), .p2_win(p2_win), .grid_full(grid_full),
        .a_led(a_led), .b_led(b_led), .c_led(c_led),
        .d_led(d_led), .e_led(e_led), .f_led(f_led),
        .g_led(g_led), .h_led(h_led), .i_led(i_led)
    );

    // Reference model: 0 = empty, 1 = player 1, 2 = player 2.
    int board [9];
    int who;
    int cyc;
    logic [8:0] seen1, seen2;
    int win_lines [8][3] = '{
        '{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}
    };

    function automatic bit owns_line(int p);
        for (int l = 0; l < 8; l++)
            if (board[win_lines[l][0]] == p &&
                board[win_lines[l][1]] == p &&
                board[win_lines[l][2]] == p)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit full();
        for (int k = 0; k < 9; k++)
            if (board[k] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit over();
        return owns_line(1) || owns_line(2) || full();
    endfunction

    function automatic logic [13:0] model_out();
        logic [8:0] leds;
        bit bl;
        bl = ((cyc >> (BD - 1)) & 1) != 0;
        for (int k = 0; k < 9; k++)
            leds[k] = (board[k] == 1) || (board[k] == 2 && bl);
        return {!over() && who == 1, !over() && who == 2,
                owns_line(1), owns_line(2), full(), leds};
    endfunction

    // A press is noticed one edge after it is sampled.
    task automatic model_edge();
        logic [8:0] ev;
        if (reset) begin
            for (int k = 0; k < 9; k++) board[k] = 0;
            who = 1;
            seen1 = btn;
            seen2 = btn;
            cyc = 0;
        end else begin
            ev = seen1 & ~seen2;
            if (!over()) begin
                for (int k = 0; k < 9; k++) begin
                    if (ev[k] && board[k] == 0) begin
                        board[k] = who;
                        who = 3 - who;
                        break;
                    end
                end
            end
            seen2 = seen1;
            seen1 = btn;
            cyc++;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(string tag = "cycle");
        logic [13:0] obs;
        @(posedge clk);
        model_edge();
        #1;
        obs = {p1_turn, p2_turn, p1_win, p2_win, grid_full,
               i_led, h_led, g_led, f_led, e_led,
               d_led, c_led, b_led, a_led};
        chk(tag, 32'(obs), 32'(model_out()));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick("reset");
        reset = 1'b0;
    endtask

    task automatic press(int k);
        btn[k] = 1'b1;
        tick("press");
        btn[k] = 1'b0;
        tick("move");
        tick("settle");
    endtask

    initial begin
        int seq1 [6] = '{0, 1, 3, 4, 8, 7};
        int seq2 [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        bit b_hi, b_lo;

        do_reset();
        tick("idle");
        chk("rst_p1_turn", 32'(p1_turn), 32'd1);
        chk("rst_flags", 32'({p2_turn, p1_win, p2_win, grid_full}), 32'd0);

        press(0);
        chk("a_led_on", 32'(a_led), 32'd1);
        chk("turn_after_a", 32'({p1_turn, p2_turn}), 32'b01);
        press(0);
        chk("repress_a_turn", 32'(p2_turn), 32'd1);

        btn[1] = 1'b1;
        repeat (10) tick("hold_b");
        btn[1] = 1'b0;
        b_hi = 0;
        b_lo = 0;
        repeat (20) begin
            tick("blink_b");
            if (b_led) b_hi = 1;
            else b_lo = 1;
        end
        chk("hold_b_single", 32'({p1_turn, p2_turn}), 32'b10);
        chk("b_blinks", 32'({b_hi, b_lo}), 32'b11);

        do_reset();
        foreach (seq1[n]) press(seq1[n]);
        chk("col_beh_p2_win", 32'(p2_win), 32'd1);
        chk("over_turns", 32'({p1_turn, p2_turn}), 32'd0);
        press(5);
        chk("f_ignored", 32'({f_led, p1_win, p2_win, grid_full}), 32'b0010);

        do_reset();
        btn[2] = 1'b1;
        btn[6] = 1'b1;
        tick("cg_press");
        btn = '0;
        tick("cg_move");
        chk("c_taken", 32'({c_led, g_led}), 32'b10);
        chk("one_toggle", 32'({p1_turn, p2_turn}), 32'b01);

        do_reset();
        foreach (seq2[n]) press(seq2[n]);
        chk("draw_flags",
            32'({grid_full, p1_win, p2_win, p1_turn, p2_turn}),
            32'b10000);
        do_reset();
        tick("post_reset");
        chk("reset_again",
            32'({p1_turn, p2_turn, p1_win, p2_win, grid_full}),
            32'b10000);

        repeat (600) begin
            btn = '0;
            if ($urandom_range(0, 2) == 0) btn[$urandom_range(0, 8)] = 1'b1;
            if ($urandom_range(0, 9) == 0) btn[$urandom_range(0, 8)] = 1'b1;
            reset = (over() && $urandom_range(0, 5) == 0) ||
                    $urandom_range(0, 199) == 0;
            tick("random");
        end
        reset = 1'b0;
        btn = '0;
        tick("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
